// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_BURST = 1'b1;

  localparam int unsigned STAT_W = 16;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request above last_owner, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  // Scan last_owner+1 .. last_owner+NUM_REQ, keeping the first hit.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_owner) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NUM_REQ
// requesters, granting bursts of up to BURST_LEN words.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester accepted-word
// counters (word_cnt) and a full-stall cycle counter (stall_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ID_W      = 2
) (
  input  logic                           wclk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             in_valid,
  input  logic [NUM_REQ-1:0]             in_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   in_data,
  output logic [NUM_REQ-1:0]             in_ready,
  input  logic                           fifo_full,
  output logic                           wr_en,
  output logic [DATA_SIZE-1:0]           wr_data,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      word_cnt,
  output logic [STAT_W-1:0]              stall_cnt
`endif
);

  localparam int unsigned     CNT_W     = clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(NUM_REQ - 1);

  logic                 state;
  logic                 state_nxt;
  logic [CNT_W-1:0]     beat_cnt;
  logic [ID_W-1:0]      last_owner;
  logic [ID_W-1:0]      winner;
  logic                 any_req;
  logic                 accept;
  logic                 burst_end;
  logic [DATA_SIZE-1:0] words [NUM_REQ];

  // Split the flat data bus into per-requester words.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = in_data[i*DATA_SIZE +: DATA_SIZE];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (in_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State register.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Next state: arbitrate in IDLE, return to IDLE on the single burst-end event.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_req)   state_nxt = ARB_BURST;
      default:  if (burst_end) state_nxt = ARB_IDLE;
    endcase
  end

  // Handshake decode: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    in_ready  = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    if (state == ARB_BURST) begin
      in_ready[grant_id] = ~fifo_full;
      accept    = in_valid[grant_id] & ~fifo_full;
      burst_end = (accept & (in_last[grant_id] | (beat_cnt == LAST_BEAT)))
                | (~in_valid[grant_id] & ~fifo_full);
    end
  end

  assign busy = (state == ARB_BURST);

  // Grant, beat count, rotation pointer and the one-cycle write pipeline.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_owner <= LAST_REQ;
      wr_en      <= 1'b0;
      wr_data    <= '0;
    end else begin
      wr_en <= accept;
      if (accept) wr_data <= words[grant_id];
      if ((state == ARB_IDLE) && any_req) begin
        grant_id <= winner;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (burst_end) last_owner <= grant_id;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] word_q;
  logic [STAT_W-1:0]              stall_q;

  // Wrapping accepted-word counters and a saturating stall counter.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      stall_q <= '0;
    end else begin
      if (accept) word_q[grant_id] <= word_q[grant_id] + STAT_W'(1);
      if (busy && fifo_full && (stall_q != {STAT_W{1'b1}}))
        stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign word_cnt  = word_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;
  localparam int IW   = 2;
  localparam int NCYC = 1500;
  localparam int NDRN = 10;

  logic              wclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     in_valid = '0;
  logic [NR-1:0]     in_last = '0;
  logic [NR*DW-1:0]  in_data = '0;
  logic [NR-1:0]     in_ready;
  logic              fifo_full = 1'b0;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic [IW-1:0]     grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  word_cnt;
  logic [15:0]       stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_SIZE (DW),
    .BURST_LEN (BL),
    .ID_W      (IW)
  ) dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   did_rst = 1'b0;

  // Reference model: who owns the port and how many words it has moved.
  bit   m_busy;
  int   m_owner;
  int   m_beats;
  int   m_last;
  int   m_gid;
  int   m_words[NR];
  int   m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_last  = NR - 1;
    m_gid   = 0;
    m_stall = 0;
    for (int r = 0; r < NR; r++) m_words[r] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int r;
    if (!m_busy) begin
      if (in_valid != '0) begin
        for (int k = 1; k <= NR; k++) begin
          r = (m_last + k) % NR;
          if (in_valid[r]) begin
            m_owner = r;
            break;
          end
        end
        m_gid   = m_owner;
        m_beats = 0;
        m_busy  = 1'b1;
      end
    end else if (fifo_full) begin
      m_stall++;
    end else if (in_valid[m_owner]) begin
      exp_q.push_back('{cyc: cyc, data: in_data[m_owner*DW +: DW]});
      m_words[m_owner]++;
      m_beats++;
      if (in_last[m_owner] || (m_beats == BL)) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
  endtask

  task automatic drive_zero();
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    fifo_full = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_wr_en",    32'(wr_en),    32'd0);
    check("rst_wr_data",  32'(wr_data),  32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Stimulus and cycle-level handshake checks.
  initial begin
    model_reset();
    drive_zero();
    rst_n = 1'b0;
    repeat (2) @(negedge wclk);
    check_reset_values();
    rst_n = 1'b1;

    for (int c = 0; c < NCYC + NDRN; c++) begin
      @(negedge wclk);
      cyc++;
      if (!did_rst && (c > 600) && m_busy && (m_beats >= 1)) begin
        did_rst = 1'b1;
        rst_n = 1'b0;
        drive_zero();
        #1;
        check_reset_values();
        exp_q.delete();
        model_reset();
        continue;
      end
      rst_n = 1'b1;
      for (int r = 0; r < NR; r++) in_data[r*DW +: DW] = DW'($urandom);
      if (c >= NCYC) begin
        in_valid  = '0;
        in_last   = '0;
        fifo_full = 1'b0;
      end else if (c < 60) begin
        in_valid  = '1;
        in_last   = '0;
        fifo_full = 1'b0;
      end else begin
        for (int r = 0; r < NR; r++) begin
          in_valid[r] = ($urandom_range(0, 3) != 0);
          in_last[r]  = ($urandom_range(0, 4) == 0);
        end
        fifo_full = ((c % 50) >= 44) || ($urandom_range(0, 9) == 0);
      end
      #1;
      check("in_ready", 32'(in_ready), (m_busy && !fifo_full) ? (32'd1 << m_owner) : 32'd0);
      check("busy",     32'(busy),     32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      model_step();
    end

    @(negedge wclk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    for (int r = 0; r < NR; r++) check("word_cnt", 32'(word_cnt[r*16 +: 16]), 32'(m_words[r] & 16'hFFFF));
    check("stall_cnt", 32'(stall_cnt), 32'((m_stall > 65535) ? 65535 : m_stall));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: every write must match the oldest expected word, one cycle after acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL wr_unexpected cyc=%0d actual=wr_en=1 data=%0h required=no write", cyc, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_data",    32'(wr_data), 32'(e.data));
          check("wr_latency", 32'(cyc),     32'(e.cyc + 1));
        end
      end else if ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL wr_missing cyc=%0d actual=wr_en=%b required=write of %0h", cyc, wr_en, e.data);
      end
    end
  end

endmodule
